// File: rtl/order_ht_sequencer_pkg.sv
// Shared encodings for the order-ID hash-table command sequencer.
// The opcode and table-state values must equal the hash table's own encodings.
package order_ht_sequencer_pkg;

    localparam logic [1:0] HT_NOOP   = 2'd0;
    localparam logic [1:0] HT_INSERT = 2'd1;
    localparam logic [1:0] HT_LOOKUP = 2'd2;
    localparam logic [1:0] HT_ERASE  = 2'd3;

    localparam logic [1:0] HT_IDLE      = 2'd0;
    localparam logic [1:0] HT_SEARCHING = 2'd1;
    localparam logic [1:0] HT_INSERTING = 2'd2;
    localparam logic [1:0] HT_DONE      = 2'd3;

    typedef enum logic [1:0] {
        CMD_REPLACE = 2'd0,
        CMD_ADD     = 2'd1,
        CMD_CANCEL  = 2'd2,
        CMD_QUERY   = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_DUPLICATE = 2'd2,
        ST_FULL      = 2'd3
    } rsp_status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } seq_state_e;

    // First table operation for a command; ADD starts with a LOOKUP.
    function automatic logic [1:0] first_op(input cmd_type_e t);
        case (t)
            CMD_REPLACE: first_op = HT_INSERT;
            CMD_ADD:     first_op = HT_LOOKUP;
            CMD_CANCEL:  first_op = HT_ERASE;
            default:     first_op = HT_LOOKUP;
        endcase
    endfunction

endpackage

// File: rtl/order_ht_sequencer_cmd_fifo.sv
// Synchronous command FIFO with a registered head word.
// Push and pop in the same cycle are both honoured, also when full.
module order_ht_sequencer_cmd_fifo
    import order_ht_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
            // Head tracks the oldest entry; an entry pushed into an emptying FIFO bypasses storage.
            if (do_pop) begin
                if (count > (AW+1)'(1)) begin
                    head <= mem[rd_ptr + 1'b1];
                end else if (do_push) begin
                    head <= data_in;
                end
            end else if (do_push && empty) begin
                head <= data_in;
            end
        end
    end

endmodule

// File: rtl/order_ht_sequencer.sv
// Command front-end for the order-ID hash table: buffers commands, runs one or two
// table operations per command and returns one status response per command.
module order_ht_sequencer
    import order_ht_sequencer_pkg::*;
#(
    parameter int KEY_WIDTH   = 32,
    parameter int VALUE_WIDTH = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_type,
    input  logic [KEY_WIDTH-1:0]   cmd_key,
    input  logic [VALUE_WIDTH-1:0] cmd_value,
    output logic [1:0]             ht_op,
    output logic [KEY_WIDTH-1:0]   ht_key,
    output logic [VALUE_WIDTH-1:0] ht_value_in,
    input  logic [VALUE_WIDTH-1:0] ht_value_out,
    input  logic                   ht_success,
    input  logic [1:0]             ht_state,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_type,
    output logic [KEY_WIDTH-1:0]   rsp_key,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic [1:0]             rsp_status,
    output logic [STAT_WIDTH-1:0]  stat_dup,
    output logic [STAT_WIDTH-1:0]  stat_miss,
    output logic [STAT_WIDTH-1:0]  stat_full
);

    // Handshakes: a stream transfer happens on a rising clk edge where valid and ready are both 1;
    // the sender holds valid and payload stable until that edge, and ready never waits on a later valid.
    localparam int EW = 2 + KEY_WIDTH + VALUE_WIDTH;

    logic [EW-1:0]          fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    cmd_type_e              head_type;
    logic [KEY_WIDTH-1:0]   head_key;
    logic [VALUE_WIDTH-1:0] head_value;

    seq_state_e             state_q, state_d;
    cmd_type_e              cur_type_q, cur_type_d;
    logic [KEY_WIDTH-1:0]   cur_key_q, cur_key_d;
    logic [VALUE_WIDTH-1:0] cur_value_q, cur_value_d;
    logic                   phase2_q, phase2_d;
    logic [1:0]             ht_op_q, ht_op_d;
    logic [KEY_WIDTH-1:0]   ht_key_q, ht_key_d;
    logic [VALUE_WIDTH-1:0] ht_value_q, ht_value_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [1:0]             rsp_type_q, rsp_type_d;
    logic [KEY_WIDTH-1:0]   rsp_key_q, rsp_key_d;
    logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
    rsp_status_e            rsp_status_q, rsp_status_d;
    logic [STAT_WIDTH-1:0]  stat_dup_q, stat_dup_d;
    logic [STAT_WIDTH-1:0]  stat_miss_q, stat_miss_d;
    logic [STAT_WIDTH-1:0]  stat_full_q, stat_full_d;
    logic                   finish;
    rsp_status_e            res_status;
    logic [VALUE_WIDTH-1:0] res_value;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    order_ht_sequencer_cmd_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .data_in ({cmd_type, cmd_key, cmd_value}),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_type  = cmd_type_e'(fifo_head[EW-1 -: 2]);
    assign head_key   = fifo_head[VALUE_WIDTH +: KEY_WIDTH];
    assign head_value = fifo_head[VALUE_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        cur_type_d   = cur_type_q;
        cur_key_d    = cur_key_q;
        cur_value_d  = cur_value_q;
        phase2_d     = phase2_q;
        ht_op_d      = ht_op_q;
        ht_key_d     = ht_key_q;
        ht_value_d   = ht_value_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_type_d   = rsp_type_q;
        rsp_key_d    = rsp_key_q;
        rsp_value_d  = rsp_value_q;
        rsp_status_d = rsp_status_q;
        stat_dup_d   = stat_dup_q;
        stat_miss_d  = stat_miss_q;
        stat_full_d  = stat_full_q;
        fifo_pop     = 1'b0;
        finish       = 1'b0;
        res_status   = ST_OK;
        res_value    = '0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !rsp_valid_q) begin
                    fifo_pop    = 1'b1;
                    cur_type_d  = head_type;
                    cur_key_d   = head_key;
                    cur_value_d = head_value;
                    phase2_d    = 1'b0;
                    ht_op_d     = first_op(head_type);
                    ht_key_d    = head_key;
                    ht_value_d  = head_value;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // DONE here is the table bouncing a NOOP, not our result.
                if (ht_state == HT_SEARCHING) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ht_state == HT_DONE) begin
                    finish = 1'b1;
                    case (cur_type_q)
                        CMD_REPLACE: begin
                            res_status = ht_success ? ST_OK : ST_FULL;
                            res_value  = ht_success ? ht_value_out : '0;
                        end
                        CMD_ADD: begin
                            if (!phase2_q) begin
                                if (ht_success) begin
                                    res_status = ST_DUPLICATE;
                                    res_value  = ht_value_out;
                                end else begin
                                    // Miss: the table picks up INSERT in its next IDLE cycle.
                                    finish   = 1'b0;
                                    phase2_d = 1'b1;
                                    ht_op_d  = HT_INSERT;
                                    state_d  = S_ISSUE;
                                end
                            end else begin
                                res_status = ht_success ? ST_OK : ST_FULL;
                                res_value  = ht_success ? cur_value_q : '0;
                            end
                        end
                        default: begin
                            res_status = ht_success ? ST_OK : ST_NOT_FOUND;
                            res_value  = ht_success ? ht_value_out : '0;
                        end
                    endcase
                    if (finish) begin
                        ht_op_d      = HT_NOOP;
                        rsp_valid_d  = 1'b1;
                        rsp_type_d   = cur_type_q;
                        rsp_key_d    = cur_key_q;
                        rsp_value_d  = res_value;
                        rsp_status_d = res_status;
                        state_d      = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    case (rsp_status_q)
                        ST_DUPLICATE: stat_dup_d  = stat_dup_q + STAT_WIDTH'(1);
                        ST_NOT_FOUND: stat_miss_d = stat_miss_q + STAT_WIDTH'(1);
                        ST_FULL:      stat_full_d = stat_full_q + STAT_WIDTH'(1);
                        default:      ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_type_q   <= CMD_REPLACE;
            cur_key_q    <= '0;
            cur_value_q  <= '0;
            phase2_q     <= 1'b0;
            ht_op_q      <= HT_NOOP;
            ht_key_q     <= '0;
            ht_value_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_type_q   <= '0;
            rsp_key_q    <= '0;
            rsp_value_q  <= '0;
            rsp_status_q <= ST_OK;
            stat_dup_q   <= '0;
            stat_miss_q  <= '0;
            stat_full_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_type_q   <= cur_type_d;
            cur_key_q    <= cur_key_d;
            cur_value_q  <= cur_value_d;
            phase2_q     <= phase2_d;
            ht_op_q      <= ht_op_d;
            ht_key_q     <= ht_key_d;
            ht_value_q   <= ht_value_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_type_q   <= rsp_type_d;
            rsp_key_q    <= rsp_key_d;
            rsp_value_q  <= rsp_value_d;
            rsp_status_q <= rsp_status_d;
            stat_dup_q   <= stat_dup_d;
            stat_miss_q  <= stat_miss_d;
            stat_full_q  <= stat_full_d;
        end
    end

    assign ht_op       = ht_op_q;
    assign ht_key      = ht_key_q;
    assign ht_value_in = ht_value_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_type    = rsp_type_q;
    assign rsp_key     = rsp_key_q;
    assign rsp_value   = rsp_value_q;
    assign rsp_status  = rsp_status_q;
    assign stat_dup    = stat_dup_q;
    assign stat_miss   = stat_miss_q;
    assign stat_full   = stat_full_q;

endmodule

// File: tb/tb_order_ht_sequencer.sv
// Directed bench for order_ht_sequencer with a small behavioural hash-table model
// (pool size adjustable) that follows the op/state handshake.
module tb_order_ht_sequencer;
    import order_ht_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic [31:0] cmd_key = '0;
    logic [63:0] cmd_value = '0;
    logic [1:0]  ht_op;
    logic [31:0] ht_key;
    logic [63:0] ht_value_in;
    logic [63:0] ht_value_out;
    logic        ht_success;
    logic [1:0]  ht_state;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_type;
    logic [31:0] rsp_key;
    logic [63:0] rsp_value;
    logic [1:0]  rsp_status;
    logic [31:0] stat_dup;
    logic [31:0] stat_miss;
    logic [31:0] stat_full;

    logic [100:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    order_ht_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_key(cmd_key), .cmd_value(cmd_value),
        .ht_op(ht_op), .ht_key(ht_key), .ht_value_in(ht_value_in),
        .ht_value_out(ht_value_out), .ht_success(ht_success), .ht_state(ht_state),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_key(rsp_key), .rsp_value(rsp_value), .rsp_status(rsp_status),
        .stat_dup(stat_dup), .stat_miss(stat_miss), .stat_full(stat_full)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1);
    end

    // Hash-table model: IDLE bounces NOOP through DONE, else SEARCHING (INSERTING) DONE.
    logic [1:0]  t_state;
    logic [1:0]  t_op;
    logic [31:0] t_key;
    logic [63:0] t_val;
    logic [31:0] tab_key [8];
    logic [63:0] tab_val [8];
    logic        tab_used [8];
    int          pool_size = 8;

    assign ht_state = t_state;

    function automatic int find_key(input logic [31:0] k);
        for (int i = 0; i < 8; i++)
            if (tab_used[i] && tab_key[i] == k) return i;
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < 8; i++)
            if (!tab_used[i]) return i;
        return -1;
    endfunction

    function automatic int used_count();
        int n = 0;
        for (int i = 0; i < 8; i++)
            if (tab_used[i]) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t_state      <= HT_IDLE;
            ht_success   <= 1'b0;
            ht_value_out <= '0;
            for (int i = 0; i < 8; i++) tab_used[i] <= 1'b0;
        end else begin
            case (t_state)
                HT_IDLE: begin
                    if (ht_op == HT_NOOP) t_state <= HT_DONE;
                    else begin
                        t_op    <= ht_op;
                        t_key   <= ht_key;
                        t_val   <= ht_value_in;
                        t_state <= HT_SEARCHING;
                    end
                end
                HT_SEARCHING: begin
                    ht_success   <= 1'b0;
                    ht_value_out <= '0;
                    t_state      <= HT_DONE;
                    case (t_op)
                        HT_LOOKUP: if (find_key(t_key) >= 0) begin
                            ht_success   <= 1'b1;
                            ht_value_out <= tab_val[find_key(t_key)];
                        end
                        HT_ERASE: if (find_key(t_key) >= 0) begin
                            ht_success   <= 1'b1;
                            ht_value_out <= tab_val[find_key(t_key)];
                            tab_used[find_key(t_key)] <= 1'b0;
                        end
                        HT_INSERT: begin
                            t_state <= HT_INSERTING;
                            if (find_key(t_key) >= 0) begin
                                tab_val[find_key(t_key)] <= t_val;
                                ht_success   <= 1'b1;
                                ht_value_out <= t_val;
                            end else if (used_count() < pool_size) begin
                                tab_used[find_free()] <= 1'b1;
                                tab_key[find_free()]  <= t_key;
                                tab_val[find_free()]  <= t_val;
                                ht_success   <= 1'b1;
                                ht_value_out <= t_val;
                            end
                        end
                        default: ;
                    endcase
                end
                HT_INSERTING: t_state <= HT_DONE;
                default:      t_state <= HT_IDLE;
            endcase
        end
    end

    // Scoreboard check
    task automatic check(input string tag, input logic [100:0] obs, input logic [100:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [100:0] rsp_word();
        return {rsp_valid, rsp_type, rsp_key, rsp_value, rsp_status};
    endfunction

    // Driver tasks (all called at a negedge, return at a negedge)
    task automatic push_cmd(input logic [1:0] t, input logic [31:0] k, input logic [63:0] v);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_key   = k;
        cmd_value = v;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("push_timeout", 101'(0), 101'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] k, input logic [63:0] v,
                        input logic [63:0] ev, input logic [1:0] es);
        exp_q.push_back({1'b1, t, k, ev, es});
        push_cmd(t, k, v);
    endtask

    task automatic get_rsp(input string tag, input int hold);
        int n = 0;
        logic [100:0] e;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid || exp_q.size() == 0) begin
            check({tag, "_timeout"}, 101'(rsp_valid), 101'(1));
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold"}, rsp_word(), e);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check(tag, rsp_word(), e);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ht"}, {35'd0, ht_op, ht_key, ht_value_in}, 101'(0));
        check({tag, "_rsp"}, rsp_word(), 101'(0));
        check({tag, "_stats"}, {5'd0, stat_dup, stat_miss, stat_full}, 101'(0));
        check({tag, "_ready"}, 101'(cmd_ready), 101'(1));
    endtask

    initial begin
        int lat;
        int n;
        @(negedge clk);
        do_reset();
        check_reset_state("reset");

        // 1: QUERY on empty table, with latency window check
        send(CMD_QUERY, 32'h15, 64'h0, 64'h0, ST_NOT_FOUND);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency", 101'((lat == 4 || lat == 5) ? 1 : 0), 101'(1));
        get_rsp("t1_query_miss", 0);
        check("t1_stat_miss", 101'(stat_miss), 101'(1));

        // 2: ADD must be new
        send(CMD_ADD, 32'h15, 64'hAAAA, 64'hAAAA, ST_OK);
        get_rsp("t2_add_ok", 0);
        send(CMD_ADD, 32'h15, 64'hBBBB, 64'hAAAA, ST_DUPLICATE);
        get_rsp("t2_add_dup", 2);
        send(CMD_QUERY, 32'h15, 64'h0, 64'hAAAA, ST_OK);
        get_rsp("t2_query", 0);
        check("t2_stat_dup", 101'(stat_dup), 101'(1));

        // 3: REPLACE then CANCEL twice
        send(CMD_REPLACE, 32'h15, 64'hCCCC, 64'hCCCC, ST_OK);
        get_rsp("t3_replace", 0);
        send(CMD_CANCEL, 32'h15, 64'h0, 64'hCCCC, ST_OK);
        get_rsp("t3_cancel_ok", 0);
        send(CMD_CANCEL, 32'h15, 64'h0, 64'h0, ST_NOT_FOUND);
        get_rsp("t3_cancel_miss", 0);
        check("t3_stat_miss", 101'(stat_miss), 101'(2));

        // 4: back-pressure, 4 queued plus 1 in flight
        send(CMD_ADD,    32'h21, 64'h1111, 64'h1111, ST_OK);
        send(CMD_ADD,    32'h22, 64'h2222, 64'h2222, ST_OK);
        send(CMD_QUERY,  32'h21, 64'h0,    64'h1111, ST_OK);
        send(CMD_ADD,    32'h21, 64'h3333, 64'h1111, ST_DUPLICATE);
        send(CMD_CANCEL, 32'h22, 64'h0,    64'h2222, ST_OK);
        exp_q.push_back({1'b1, CMD_QUERY, 32'h22, 64'h0, ST_NOT_FOUND});
        cmd_valid = 1'b1;
        cmd_type  = CMD_QUERY;
        cmd_key   = 32'h22;
        repeat (15) @(negedge clk);
        check("t4_ready_low", 101'(cmd_ready), 101'(0));
        fork
            push_cmd(CMD_QUERY, 32'h22, 64'h0);
            get_rsp("t4_rsp0", 3);
        join
        for (int i = 1; i < 6; i++) get_rsp($sformatf("t4_rsp%0d", i), 2);
        check("t4_stat_dup", 101'(stat_dup), 101'(2));
        check("t4_stat_miss", 101'(stat_miss), 101'(3));

        // 5: pool of 2 filled, new keys report FULL, existing key still replaceable
        pool_size = 2;
        do_reset();
        check_reset_state("t5_reset");
        send(CMD_ADD,     32'h31, 64'h31,   64'h31,   ST_OK);
        get_rsp("t5_add1", 0);
        send(CMD_ADD,     32'h32, 64'h32,   64'h32,   ST_OK);
        get_rsp("t5_add2", 0);
        send(CMD_ADD,     32'h33, 64'h33,   64'h0,    ST_FULL);
        get_rsp("t5_add_full", 0);
        check("t5_stat_full1", 101'(stat_full), 101'(1));
        send(CMD_REPLACE, 32'h34, 64'h34,   64'h0,    ST_FULL);
        get_rsp("t5_replace_full", 0);
        send(CMD_REPLACE, 32'h31, 64'h5151, 64'h5151, ST_OK);
        get_rsp("t5_replace_existing", 0);
        check("t5_stat_full2", 101'(stat_full), 101'(2));

        // 6: reset while an ADD lookup is in flight, one more command queued
        push_cmd(CMD_ADD, 32'h41, 64'h4141);
        push_cmd(CMD_QUERY, 32'h31, 64'h0);
        n = 0;
        while (ht_state != HT_SEARCHING && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_search", 101'(ht_state), 101'(HT_SEARCHING));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("t6_abort");
        repeat (10) @(negedge clk);
        check("t6_no_rsp", rsp_word(), 101'(0));
        send(CMD_QUERY, 32'h31, 64'h0,    64'h0,    ST_NOT_FOUND);
        get_rsp("t6_query_after", 0);
        send(CMD_ADD,   32'h41, 64'h4141, 64'h4141, ST_OK);
        get_rsp("t6_add_after", 0);
        send(CMD_QUERY, 32'h41, 64'h0,    64'h4141, ST_OK);
        get_rsp("t6_query_added", 1);
        check("t6_stat_miss", 101'(stat_miss), 101'(1));

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/order_ht_sequencer.md
Name: order_ht_sequencer

Overview:
- Upstream command front-end for the order-ID hash table.
- Accepts order commands (REPLACE, ADD, CANCEL, QUERY) through a valid/ready stream and buffers them in a small FIFO.
- Translates each command into one or two hash-table operations using the table's op/state handshake, and returns one response per command with a status code.
- Enforces ADD-must-be-new semantics: an ADD is a LOOKUP followed by an INSERT only if the LOOKUP misses.

Parameters:
- KEY_WIDTH, 32, order-ID width; must match the hash table.
- VALUE_WIDTH, 64, handle width; must match the hash table.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_type  in  2  0=REPLACE, 1=ADD, 2=CANCEL, 3=QUERY
- cmd_key  in  KEY_WIDTH  order ID
- cmd_value  in  VALUE_WIDTH  handle (REPLACE/ADD only)
- ht_op  out  2  to table: 0 NOOP, 1 INSERT, 2 LOOKUP, 3 ERASE
- ht_key  out  KEY_WIDTH  to table
- ht_value_in  out  VALUE_WIDTH  to table
- ht_value_out  in  VALUE_WIDTH  from table
- ht_success  in  1  from table
- ht_state  in  2  from table: 0 IDLE, 1 SEARCHING, 2 INSERTING, 3 DONE
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_type  out  2  echoed cmd_type
- rsp_key  out  KEY_WIDTH  echoed key
- rsp_value  out  VALUE_WIDTH  result value
- rsp_status  out  2  0 OK, 1 NOT_FOUND, 2 DUPLICATE, 3 FULL
- stat_dup  out  STAT_WIDTH  count of DUPLICATE responses
- stat_miss  out  STAT_WIDTH  count of NOT_FOUND responses
- stat_full  out  STAT_WIDTH  count of FULL responses

Behaviour:

Reset and clocking:
- Reset is rst, synchronous, active-high; clock is clk.
- rst is shared with the hash table.
- Reset values: ht_op=NOOP, ht_key=0, ht_value_in=0, rsp_valid=0, rsp_* =0, all stat_* =0.
- Reset flushes the FIFO (cmd_ready=1 the cycle after rst deasserts).
- Reset mid-operation abandons the command; no response is produced for it.

FIFO:
- Push occurs on cmd_valid & cmd_ready.
- cmd_ready=0 when FIFO_DEPTH entries are held.
- Pop occurs only on the S_IDLE→S_ISSUE transition.
- A push and a pop in the same cycle are both honoured, including when the FIFO is full.

All ht_* outputs are registered. ht_op is NOOP whenever no operation is outstanding.

FSM:
- S_IDLE: if the FIFO is non-empty and rsp_valid=0, pop the head, latch type/key/value, drive ht_key/ht_value_in, and set ht_op to:
  - INSERT for REPLACE
  - LOOKUP for ADD
  - ERASE for CANCEL
  - LOOKUP for QUERY
  Then go to S_ISSUE.
- S_ISSUE: hold ht_op/key/value stable. When ht_state==SEARCHING, go to S_WAIT.
  - A DONE seen in S_ISSUE is the table's NOOP round trip and must be ignored.
- S_WAIT: hold the inputs until ht_state==DONE. In that cycle, capture ht_success/ht_value_out and decide the outcome:
  - REPLACE: success → OK, value=ht_value_out. Fail → FULL, value=0.
  - CANCEL: success → OK, value=erased handle. Fail → NOT_FOUND, value=0.
  - QUERY: success → OK, value=stored handle. Fail → NOT_FOUND, value=0.
  - ADD, phase 1 (LOOKUP): success → DUPLICATE, value=existing handle. Fail → set ht_op=INSERT (same key/value), go to S_ISSUE for phase 2. The table samples INSERT in its following IDLE cycle, with no NOOP gap.
  - ADD, phase 2 (INSERT): success → OK, value=cmd_value. Fail → FULL, value=0.
  - Final outcome: ht_op=NOOP, rsp_valid=1, go to S_RESP.
- S_RESP: hold all rsp_* until rsp_ready. Then rsp_valid=0, increment the matching stat counter, go to S_IDLE.
  - rsp_valid and rsp_* are stable while rsp_ready=0.

Other rules:
- Stat counters wrap modulo 2^STAT_WIDTH.
- Only one command is outstanding at a time. A new command is popped no earlier than the cycle after the response handshake.

Latency (QUERY, empty bucket, FIFO empty, table IDLE, rsp_ready=1):
- Push at cycle 0, ht_op driven at 2, table SEARCHING at 3, DONE at 4, rsp_valid at 5.
- rsp_valid lands at cycle 5 or 6, depending on the table's NOOP bounce phase.

Decomposition:
- Shared package holds:
  - The opcode localparams NOOP/INSERT/LOOKUP/ERASE and table state encodings IDLE/SEARCHING/INSERTING/DONE; these must equal the table's encodings.
  - Command type and response status encodings.
- One sub-module: cmd_fifo, a synchronous FIFO with parameters width and depth, push/pop/full/empty, and registered head output.

Test Plan:
1. QUERY key 0x15 on an empty table → rsp status NOT_FOUND, value 0, stat_miss=1.
2. ADD key 0x15, value 0xAAAA → OK with value 0xAAAA. Then ADD key 0x15, value 0xBBBB → DUPLICATE with value 0xAAAA. Then QUERY 0x15 → OK with 0xAAAA, confirming the table was not overwritten. stat_dup=1.
3. REPLACE 0x15, value 0xCCCC → OK. Then CANCEL 0x15 → OK with value 0xCCCC. Then CANCEL 0x15 → NOT_FOUND.
4. Push 6 commands back-to-back with rsp_ready=0 → cmd_ready drops after 4 queued plus 1 in flight. Responses come out in order, each held stable until accepted.
5. Table with POOL_SIZE=2 holding 2 entries: ADD a new key → FULL, stat_full=1. REPLACE a new key → FULL.
6. Assert rst during S_WAIT of an ADD phase 1 → ht_op=NOOP, rsp_valid=0, FIFO empty, counters 0. The next command completes normally.
